truth_table_sequencer: RTL

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_sequencer
//  Purpose  : Sweeps the four (x,y) input vectors of a 2-input gate, holds
//             each for SETTLE_CYCLES clocks, samples z at the end of the
//             hold and assembles the 4-entry truth table (bit i = z for
//             vector i, vector i drives x = i[1], y = i[0]).
//  Options  : Define TT_CHECK_EN to add output 'pass', the registered
//             comparison of the captured table against EXPECTED_TABLE.
//  Revision : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter logic [3:0]  EXPECTED_TABLE = 4'b0110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       z_in,
  output logic       x_out,
  output logic       y_out,
  output logic       busy,
  output logic       done,
`ifdef TT_CHECK_EN
  output logic       pass,
`endif
  output logic [3:0] table_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Settle counter terminal value; the counter is 8 bits wide to cover 1..255.
  localparam logic [7:0] C_CNT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] C_IDX_LAST = 2'd3;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_idx;
  logic [1:0] w_idx_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic [3:0] r_table;
  logic [3:0] w_table_next;
  logic       w_accept;

  // A start is accepted only in IDLE and only when abort is not also high.
  assign w_accept = (r_state == ST_IDLE) && start && !abort;

  // State and datapath registers; reset discards any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_cnt   <= 8'd0;
      r_table <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_table <= w_table_next;
    end
  end

  // Next-state logic: settle counting, sampling and vector advance.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_table_next = r_table;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_RUN;
          w_idx_next   = 2'd0;
          w_cnt_next   = 8'd0;
          w_table_next = 4'd0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Cancel keeps whatever was already captured.
          w_state_next = ST_IDLE;
          w_idx_next   = 2'd0;
          w_cnt_next   = 8'd0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_table_next[r_idx] = z_in;
          w_cnt_next          = 8'd0;
          if (r_idx == C_IDX_LAST) begin
            // Last vector sampled: finish rather than wrap the index.
            w_state_next = ST_DONE;
            w_idx_next   = 2'd0;
          end else begin
            w_idx_next = r_idx + 2'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idx_next   = 2'd0;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // Output decode: gate inputs are only driven while a sweep is running.
  always_comb begin
    x_out = 1'b0;
    y_out = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    if (r_state == ST_RUN) begin
      x_out = r_idx[1];
      y_out = r_idx[0];
      busy  = 1'b1;
    end
    if (r_state == ST_DONE) begin
      done = 1'b1;
    end
  end

  assign table_out = r_table;

`ifdef TT_CHECK_EN
  logic r_pass;
  logic w_pass_next;

  // Pass flag is evaluated on the final table as DONE is entered.
  always_comb begin
    w_pass_next = r_pass;
    if (w_accept) begin
      w_pass_next = 1'b0;
    end else if ((r_state == ST_RUN) && (w_state_next == ST_DONE)) begin
      w_pass_next = (w_table_next == EXPECTED_TABLE);
    end
  end

  // Pass register, held until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else begin
      r_pass <= w_pass_next;
    end
  end

  assign pass = r_pass;
`else
  // The golden table has no consumer without the checker.
  logic w_unused_expected;
  assign w_unused_expected = ^EXPECTED_TABLE;
`endif

endmodule
`default_nettype wire
